// File: rtl/epp_cmd_decoder.sv
// epp_cmd_decoder
//
// Turns EPP parallel-port byte writes into validated three-byte commands
// (command, key, data) and hands each one downstream on a valid/ready
// handshake. Illegal codes, a bad key byte, an inter-byte stall or a byte
// arriving while a command is still pending are discarded and flagged.
//
// Optional feature macro: EPP_CMD_STATS_EN
//   defined     - frameCnt / errCnt count handshakes / error pulses,
//                 saturating at 0xFF, cleared only by rstN
//   not defined - frameCnt / errCnt tied to 0x00
//
// Ports
//   clk        in   system clock
//   rstN       in   asynchronous active-low reset
//   busBramIn  in   [7:0] EPP data byte, stable while dataStb is low
//   dataStb    in   EPP data strobe, active low, asynchronous to clk
//   cmdReady   in   downstream can accept a command
//   cmdValid   out  command held on cmdCode/cmdData
//   cmdCode    out  [7:0] validated command byte
//   cmdData    out  [7:0] data byte of the frame
//   frameErr   out  one-cycle pulse per discarded frame or byte
//   busy       out  high whenever the FSM is not in IDLE
//   frameCnt   out  [7:0] completed-frame count
//   errCnt     out  [7:0] error count
//
// State | meaning
// IDLE  | waiting for a command byte
// KEY   | command accepted, waiting for the key byte
// DATA  | key matched, waiting for the data byte
// ISSUE | command presented on cmdValid until cmdReady

module epp_cmd_decoder #(
    parameter logic [7:0] FRAME_KEY   = 8'h55,
    parameter int         MAX_CMD     = 4,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [7:0] busBramIn,
    input  logic       dataStb,
    input  logic       cmdReady,
    output logic       cmdValid,
    output logic [7:0] cmdCode,
    output logic [7:0] cmdData,
    output logic       frameErr,
    output logic       busy,
    output logic [7:0] frameCnt,
    output logic [7:0] errCnt
);

    localparam logic [7:0]  MAX_CODE    = 8'(MAX_CMD);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEY   = 2'd1,
        DATA  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  stbSync;
    logic        stbPrev;
    logic        byteEvt;
    logic        cmdLegal;
    logic [7:0]  codeShadow;
    logic [15:0] toCnt;

    // Strobe synchronizer idles high so reset never looks like a falling edge.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stbSync <= 2'b11;
            stbPrev <= 1'b1;
        end else begin
            stbSync <= {stbSync[0], dataStb};
            stbPrev <= stbSync[1];
        end
    end

    assign byteEvt  = stbPrev & ~stbSync[1];
    assign cmdLegal = (busBramIn != 8'h00) && (busBramIn <= MAX_CODE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            cmdValid   <= 1'b0;
            cmdCode    <= 8'h00;
            cmdData    <= 8'h00;
            frameErr   <= 1'b0;
            busy       <= 1'b0;
            codeShadow <= 8'h00;
            toCnt      <= 16'h0000;
        end else begin
            frameErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (byteEvt) begin
                        if (cmdLegal) begin
                            codeShadow <= busBramIn;
                            toCnt      <= 16'h0000;
                            state      <= KEY;
                            busy       <= 1'b1;
                        end else begin
                            frameErr <= 1'b1;
                        end
                    end
                end
                KEY: begin
                    // A byte on the same cycle as the timeout takes priority.
                    if (byteEvt) begin
                        toCnt <= 16'h0000;
                        if (busBramIn == FRAME_KEY) begin
                            state <= DATA;
                        end else begin
                            frameErr <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end
                    end else if (toCnt == TIMEOUT_LIM) begin
                        frameErr <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        toCnt <= toCnt + 16'h0001;
                    end
                end
                DATA: begin
                    if (byteEvt) begin
                        toCnt    <= 16'h0000;
                        cmdData  <= busBramIn;
                        cmdCode  <= codeShadow;
                        cmdValid <= 1'b1;
                        state    <= ISSUE;
                    end else if (toCnt == TIMEOUT_LIM) begin
                        frameErr <= 1'b1;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        toCnt <= toCnt + 16'h0001;
                    end
                end
                ISSUE: begin
                    // A byte arriving here is dropped; the pending command stays put.
                    if (byteEvt) begin
                        frameErr <= 1'b1;
                    end
                    if (cmdReady) begin
                        cmdValid <= 1'b0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cmdValid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

`ifdef EPP_CMD_STATS_EN
    logic [7:0] frameCntQ;
    logic [7:0] errCntQ;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            frameCntQ <= 8'h00;
            errCntQ   <= 8'h00;
        end else begin
            if (cmdValid && cmdReady && (frameCntQ != 8'hFF)) begin
                frameCntQ <= frameCntQ + 8'h01;
            end
            if (frameErr && (errCntQ != 8'hFF)) begin
                errCntQ <= errCntQ + 8'h01;
            end
        end
    end

    assign frameCnt = frameCntQ;
    assign errCnt   = errCntQ;
`else
    assign frameCnt = 8'h00;
    assign errCnt   = 8'h00;
`endif

endmodule
